// File: rtl/vpu_pkg.sv
// Shared definitions for the VPU sequencing controller and its datapath.
//   - opcode constants for the three legal vector ops
//   - bit positions of the instruction fields in the 15-bit instruction word
//   - controller state enum and latched-instruction struct
//   - op_legal(): true for the opcodes the VPU implements
package vpu_pkg;
  localparam int NUM_LANES = 8;
  localparam int VEC_W     = 8;

  localparam logic [5:0] OP_VADD = 6'b010000;
  localparam logic [5:0] OP_VSUB = 6'b010001;
  localparam logic [5:0] OP_VDOT = 6'b010010;

  localparam int OP_MSB  = 14;
  localparam int OP_LSB  = 9;
  localparam int RD_MSB  = 8;
  localparam int RD_LSB  = 6;
  localparam int RS1_MSB = 5;
  localparam int RS1_LSB = 3;
  localparam int RS2_MSB = 2;
  localparam int RS2_LSB = 0;

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  typedef struct packed {
    logic [5:0] op;
    logic [2:0] rd;
    logic [2:0] rs1;
    logic [2:0] rs2;
  } instr_t;

  function automatic logic op_legal(input logic [5:0] op);
    return (op == OP_VADD) || (op == OP_VSUB) || (op == OP_VDOT);
  endfunction
endpackage

// File: rtl/vpu.sv
// Combinational VPU datapath: NUM_LANES independent lanes plus a dot-product
// reduction tree.
//   en       : output is forced to zero when low
//   op       : VADD / VSUB give per-lane results, VDOT gives the full-width
//              sum of lane products in the low bits
//   a, b     : packed lane operands
//   out      : result vector
module vpu
  import vpu_pkg::*;
#(
  parameter int NUM_LANES = 8,
  parameter int VEC_W     = 8
) (
  input  logic                             en,
  input  logic [5:0]                       op,
  input  logic [NUM_LANES-1:0][VEC_W-1:0]  a,
  input  logic [NUM_LANES-1:0][VEC_W-1:0]  b,
  output logic [NUM_LANES*VEC_W-1:0]       out
);
  localparam int SW = 2*VEC_W + $clog2(NUM_LANES);

  logic [NUM_LANES-1:0][VEC_W-1:0]   lres;
  logic [NUM_LANES-1:0][2*VEC_W-1:0] lprod;
  logic [SW-1:0]                     sum;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    vpu_lane #(.VEC_W(VEC_W)) u_lane (
      .op  (op),
      .a   (a[i]),
      .b   (b[i]),
      .res (lres[i]),
      .prod(lprod[i])
    );
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_LANES; i++) sum = sum + SW'(lprod[i]);
  end

  always_comb begin
    out = '0;
    if (en) begin
      if (op == OP_VDOT) out[SW-1:0] = sum;
      else               out = lres;
    end
  end
endmodule

// File: rtl/vpu_lane.sv
// One 8-bit VPU lane.
//   op   : opcode (selects add or subtract for res)
//   a, b : lane operands
//   res  : a+b or a-b, mod 2^VEC_W
//   prod : full-width a*b, consumed by the dot-product reduction
module vpu_lane
  import vpu_pkg::*;
#(
  parameter int VEC_W = 8
) (
  input  logic [5:0]         op,
  input  logic [VEC_W-1:0]   a,
  input  logic [VEC_W-1:0]   b,
  output logic [VEC_W-1:0]   res,
  output logic [2*VEC_W-1:0] prod
);
  assign res  = (op == OP_VSUB) ? (a - b) : (a + b);
  assign prod = (2*VEC_W)'(a) * (2*VEC_W)'(b);
endmodule

// File: rtl/vpu_regfile.sv
// NREGS x VW vector register file.
//   clk, rst_n : clock, async active-low clear of every entry
//   we, waddr, wdata : single write port (caller arbitrates WB vs host)
//   ra1/rd1, ra2/rd2 : operand read ports, combinational
//   ra3/rd3          : host read port, combinational
module vpu_regfile #(
  parameter int NREGS = 8,
  parameter int VW    = 64,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [VW-1:0] wdata,
  input  logic [AW-1:0] ra1,
  output logic [VW-1:0] rd1,
  input  logic [AW-1:0] ra2,
  output logic [VW-1:0] rd2,
  input  logic [AW-1:0] ra3,
  output logic [VW-1:0] rd3
);
  logic [NREGS-1:0][VW-1:0] mem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  mem        <= '0;
    else if (we) mem[waddr] <= wdata;
  end

  assign rd1 = mem[ra1];
  assign rd2 = mem[ra2];
  assign rd3 = mem[ra3];
endmodule

// File: rtl/vpu_seq_ctrl.sv
// Sequencing controller for the 8-lane VPU.
// Accepts one instruction at a time (IDLE -> EXEC -> WB), reads two source
// registers in EXEC, captures the VPU result, and writes it back in WB.
//   clk, rst_n          : clock, async active-low reset
//   instr_valid/ready   : instruction handshake, instr = {op,rd,rs1,rs2}
//   wr_en/addr/data     : host register load, honoured only while idle
//   rd_addr/rd_data     : combinational host register read
//   busy, done, err     : not-idle, retire pulse, sticky illegal-opcode flag
//   err_clr             : clears err (a new error in the same cycle wins)
module vpu_seq_ctrl
  import vpu_pkg::*;
#(
  parameter int NREGS = 8,
  parameter int VW    = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic [14:0]              instr,
  input  logic                     wr_en,
  input  logic [$clog2(NREGS)-1:0] wr_addr,
  input  logic [VW-1:0]            wr_data,
  input  logic [$clog2(NREGS)-1:0] rd_addr,
  output logic [VW-1:0]            rd_data,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  input  logic                     err_clr
);
  localparam int AW = $clog2(NREGS);

  state_t        state, nstate;
  instr_t        iq;
  logic [VW-1:0] result_q, opa, opb, vout, wb_data;
  logic          legal, vpu_en, rf_we;
  logic [AW-1:0] rf_waddr;

  assign legal = op_legal(iq.op);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate      = state;
    instr_ready = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    vpu_en      = 1'b0;
    unique case (state)
      IDLE: begin
        instr_ready = 1'b1;
        busy        = 1'b0;
        if (instr_valid) nstate = EXEC;
      end
      EXEC: begin
        vpu_en = legal;
        nstate = WB;
      end
      WB: begin
        done   = 1'b1;
        nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  // Dot product keeps only the low byte of the sum; the upper VPU bits are
  // never allowed into the register file.
  always_comb begin
    wb_data = vout;
    if (iq.op == OP_VDOT) wb_data = {{(VW-8){1'b0}}, vout[7:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iq       <= '0;
      result_q <= '0;
      err      <= 1'b0;
    end else begin
      if (instr_valid && instr_ready) begin
        iq.op  <= instr[OP_MSB:OP_LSB];
        iq.rd  <= instr[RD_MSB:RD_LSB];
        iq.rs1 <= instr[RS1_MSB:RS1_LSB];
        iq.rs2 <= instr[RS2_MSB:RS2_LSB];
      end
      if (state == EXEC) result_q <= wb_data;
      if (state == EXEC && !legal) err <= 1'b1;
      else if (err_clr)            err <= 1'b0;
    end
  end

  // WB owns the write port; host loads only land while idle.
  assign rf_we    = (state == WB && legal) || (state == IDLE && wr_en);
  assign rf_waddr = (state == WB) ? AW'(iq.rd) : wr_addr;

  vpu_regfile #(.NREGS(NREGS), .VW(VW)) u_rf (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (rf_we),
    .waddr(rf_waddr),
    .wdata((state == WB) ? result_q : wr_data),
    .ra1  (AW'(iq.rs1)),
    .rd1  (opa),
    .ra2  (AW'(iq.rs2)),
    .rd2  (opb),
    .ra3  (rd_addr),
    .rd3  (rd_data)
  );

  vpu #(.NUM_LANES(NUM_LANES), .VEC_W(VEC_W)) u_vpu (
    .en (vpu_en),
    .op (iq.op),
    .a  (opa),
    .b  (opb),
    .out(vout)
  );
endmodule

// File: tb/tb_vpu_seq_ctrl.sv
module tb_vpu_seq_ctrl;
  import vpu_pkg::*;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        instr_valid = 1'b0, instr_ready;
  logic [14:0] instr = '0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0, rd_addr = '0;
  logic [63:0] wr_data = '0, rd_data;
  logic        busy, done, err, err_clr = 1'b0;

  int nchk = 0, nerr = 0;
  logic [63:0] mregs [8];
  logic        err_exp;

  vpu_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done), .err(err),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit is_legal(input logic [5:0] op);
    return op == 6'b010000 || op == 6'b010001 || op == 6'b010010;
  endfunction

  // Reference: byte-wise arithmetic on integers.
  function automatic logic [63:0] ref_op(input logic [5:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] r;
    int s, x, y;
    r = '0; s = 0;
    for (int i = 0; i < 8; i++) begin
      x = int'(a[8*i +: 8]);
      y = int'(b[8*i +: 8]);
      if (op == 6'b010000) r[8*i +: 8] = 8'((x + y) % 256);
      if (op == 6'b010001) r[8*i +: 8] = 8'((x - y + 256) % 256);
      s += x * y;
    end
    if (op == 6'b010010) r = {56'b0, 8'(s % 256)};
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mregs[i] = '0;
    err_exp = 1'b0;
  endtask

  task automatic load(input logic [2:0] a, input logic [63:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    mregs[a] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [2:0] a, input logic [63:0] exp);
    rd_addr = a;
    #1;
    chk(tag, rd_data, exp);
  endtask

  task automatic clear_err();
    @(negedge clk);
    err_clr = 1'b1;
    err_exp = 1'b0;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_clr", err, err_exp);
  endtask

  task automatic issue(input logic [5:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input bit ld_acc, input logic [2:0] la,
                       input logic [63:0] ld, input bit clr_exec, input bit ld_busy);
    logic [63:0] res;
    bit lg;
    lg = is_legal(op);
    @(negedge clk);
    chk("ready_idle", instr_ready, 1);
    instr_valid = 1'b1;
    instr = {op, rd, rs1, rs2};
    wr_en = ld_acc; wr_addr = la; wr_data = ld;
    if (ld_acc) mregs[la] = ld;
    res = ref_op(op, mregs[rs1], mregs[rs2]);
    @(negedge clk); // EXEC
    instr_valid = 1'b0;
    chk("exec_busy", busy, 1);
    chk("exec_ready", instr_ready, 0);
    chk("exec_done", done, 0);
    chk("exec_vpu_en", dut.vpu_en, lg);
    wr_en = ld_busy; wr_addr = rd; wr_data = ~mregs[rd];
    err_clr = clr_exec;
    if (!lg) err_exp = 1'b1;
    else if (clr_exec) err_exp = 1'b0;
    @(negedge clk); // WB
    wr_en = 1'b0; err_clr = 1'b0;
    chk("wb_done", done, 1);
    chk("wb_busy", busy, 1);
    chk("wb_err", err, err_exp);
    if (lg) mregs[rd] = res;
    @(negedge clk); // back in IDLE
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    read_chk("wb_data", rd, mregs[rd]);
  endtask

  initial begin
    logic [5:0]  op;
    logic [2:0]  rd, rs1, rs2, la;
    logic [63:0] r2_before;
    int acc;

    model_reset();
    #12;
    chk("rst_ready", instr_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    for (int i = 0; i < 8; i++) read_chk("rst_reg", 3'(i), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    load(3'd1, 64'h0102030405060708);
    load(3'd2, 64'h0101010101010101);
    issue(OP_VADD, 3'd3, 3'd1, 3'd2, 0, 0, 0, 0, 0);
    read_chk("vadd", 3'd3, 64'h0203040506070809);
    issue(OP_VSUB, 3'd4, 3'd1, 3'd2, 0, 0, 0, 0, 0);
    read_chk("vsub", 3'd4, 64'h0001020304050607);
    issue(OP_VDOT, 3'd5, 3'd1, 3'd2, 0, 0, 0, 0, 0);
    read_chk("vdot", 3'd5, 64'h0000000000000024);
    load(3'd6, '1);
    load(3'd7, '1);
    issue(OP_VDOT, 3'd5, 3'd6, 3'd7, 0, 0, 0, 0, 0);
    read_chk("vdot_ff", 3'd5, 64'h0000000000000008);

    load(3'd1, '1);
    issue(OP_VADD, 3'd1, 3'd1, 3'd2, 0, 0, 0, 0, 0);
    read_chk("wrap_add", 3'd1, 64'h0);
    issue(OP_VSUB, 3'd0, 3'd1, 3'd2, 0, 0, 0, 0, 0);
    read_chk("wrap_sub", 3'd0, 64'hFFFFFFFFFFFFFFFF);

    r2_before = mregs[2];
    issue(6'b000000, 3'd2, 3'd1, 3'd3, 0, 0, 0, 0, 0);
    read_chk("illegal_r2", 3'd2, r2_before);
    chk("illegal_err", err, 1);
    clear_err();
    issue(6'b111111, 3'd2, 3'd1, 3'd3, 0, 0, 0, 1, 0); // clear coincides with set
    chk("err_set_wins", err, 1);
    clear_err();

    // load in the accept cycle feeds the instruction; load while busy dropped
    issue(OP_VADD, 3'd3, 3'd4, 3'd2, 1, 3'd4, 64'h1010101010101010, 0, 1);
    read_chk("acc_load", 3'd3, 64'h1111111111111111);
    read_chk("busy_load", 3'd4, 64'h1010101010101010);

    // back-to-back: valid held for 9 cycles -> 3 accepts
    acc = 0;
    @(negedge clk);
    instr = {OP_VADD, 3'd3, 3'd1, 3'd2};
    instr_valid = 1'b1;
    for (int c = 0; c < 9; c++) begin
      if (instr_ready) acc++;
      @(negedge clk);
    end
    instr_valid = 1'b0;
    mregs[3] = ref_op(OP_VADD, mregs[1], mregs[2]);
    chk("b2b_accepts", 64'(acc), 64'd3);
    read_chk("b2b_r3", 3'd3, mregs[3]);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1)) load(3'($urandom), {$urandom, $urandom});
      case ($urandom_range(0, 3))
        0: op = OP_VADD;
        1: op = OP_VSUB;
        2: op = OP_VDOT;
        default: begin
          op = 6'($urandom);
          if (is_legal(op)) op = 6'h3F;
        end
      endcase
      rd = 3'($urandom); rs1 = 3'($urandom); rs2 = 3'($urandom); la = 3'($urandom);
      issue(op, rd, rs1, rs2, bit'($urandom_range(0, 1)), la, {$urandom, $urandom},
            bit'($urandom_range(0, 3) == 0), bit'($urandom_range(0, 1)));
      if (err_exp && $urandom_range(0, 1)) clear_err();
    end
    for (int i = 0; i < 8; i++) read_chk("rand_final", 3'(i), mregs[i]);

    // reset during EXEC aborts the instruction
    load(3'd1, 64'h0102030405060708);
    load(3'd2, 64'h0101010101010101);
    @(negedge clk);
    instr_valid = 1'b1;
    instr = {OP_VADD, 3'd3, 3'd1, 3'd2};
    @(negedge clk);
    instr_valid = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("abort_ready", instr_ready, 1);
    chk("abort_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("abort_done", done, 0);
    end
    read_chk("abort_r3", 3'd3, 64'h0);
    read_chk("abort_r1", 3'd1, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
